// File: rtl/load_store_unit.sv
// Memory stage: steers ALU-addressed loads/stores onto an ack-based word port, passes other ops through.
// Latency: accept-to-out_valid 1 cycle for pass-through/error, 2 cycles plus ack wait for memory ops.
// Backpressure: one op in flight; in_ready only in IDLE, mem_req held stable until mem_ack or timeout.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // Counter wide enough to hold TIMEOUT itself
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            timeout_hit;

    // Latched operation context needed after accept
    logic            ld_q;
    logic [2:0]      f3_q;
    logic [1:0]      a_lo_q;
    logic            err_q;

    // Accept-time decode of the presented operation
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            acc_load;
    logic            acc_store;
    logic            acc_mem;
    logic            acc_illegal;
    logic            acc_misal;
    logic            acc_err;
    logic            accept;
    logic [3:0]      strb_c;
    logic [XLEN-1:0] wdata_c;

    // Load extraction from the returned word
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    logic            unused_ok;

    assign opcode    = operation[6:0];
    assign f3        = operation[9:7];
    assign acc_load  = (opcode == OPC_LOAD);
    assign acc_store = (opcode == OPC_STORE);
    assign acc_mem   = acc_load | acc_store;
    assign accept    = in_valid & (state == IDLE);
    assign unused_ok = ^operation[11:10];

    assign cnt_inc     = wait_cnt + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TMAX);

    // Legality and alignment check for memory operations
    always_comb begin
        acc_illegal = 1'b0;
        acc_misal   = 1'b0;
        if (acc_load) begin
            acc_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else if (acc_store) begin
            acc_illegal = f3[2] || (f3 == 3'b011);
        end
        case (f3[1:0])
            2'b01:   acc_misal = alu_result[0];
            2'b10:   acc_misal = |alu_result[1:0];
            default: acc_misal = 1'b0;
        endcase
        acc_err = acc_mem & (acc_illegal | acc_misal);
    end

    // Store lane steering: replicate data, enable only the addressed lanes
    always_comb begin
        strb_c  = 4'b0000;
        wdata_c = store_data;
        if (acc_store) begin
            case (f3[1:0])
                2'b00: begin
                    strb_c  = 4'b0001 << alu_result[1:0];
                    wdata_c = {4{store_data[7:0]}};
                end
                2'b01: begin
                    strb_c  = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{store_data[15:0]}};
                end
                default: begin
                    strb_c  = 4'b1111;
                    wdata_c = store_data;
                end
            endcase
        end
    end

    // Pick the addressed byte/half of the read word and extend per funct3
    always_comb begin
        case (a_lo_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = a_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack takes priority over the timeout exit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (acc_mem && !acc_err) ? REQ : DONE;
                end
            end
            REQ: begin
                state_nxt = mem_ack ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        out_err   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            REQ:  mem_req  = 1'b1;
            WAIT: mem_req  = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                out_err   = err_q;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Wait-cycle counter: runs only while stalled in WAIT, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !mem_ack) begin
            wait_cnt <= cnt_inc;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Datapath: latch on accept, capture load data on ack, flag timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q      <= 1'b0;
            f3_q      <= 3'b000;
            a_lo_q    <= 2'b00;
            err_q     <= 1'b0;
            out_data  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= '0;
        end else if (accept) begin
            ld_q     <= acc_load;
            f3_q     <= f3;
            a_lo_q   <= alu_result[1:0];
            err_q    <= acc_err;
            out_data <= acc_mem ? '0 : alu_result;
            if (acc_mem && !acc_err) begin
                mem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                mem_we    <= acc_store;
                mem_wstrb <= strb_c;
                mem_wdata <= wdata_c;
            end
        end else if ((state == REQ || state == WAIT) && mem_ack) begin
            if (ld_q) begin
                out_data <= ld_ext;
            end
        end else if (state == WAIT && timeout_hit) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] operation;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mkop(input logic [2:0] f, input logic [6:0] opc);
        return {2'b00, f, opc};
    endfunction

    function automatic logic [31:0] lanemask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Reference model: expected result of one operation from the ISA rules
    function automatic void model(input logic [11:0] op, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd,
                                  output bit is_mem, output bit err, output bit we,
                                  output logic [31:0] data, output logic [3:0] strb,
                                  output logic [31:0] lanes);
        logic [6:0]  opc;
        logic [2:0]  f;
        bit          is_load, is_store, legal;
        int          size, off;
        logic [31:0] val, mask;
        opc      = op[6:0];
        f        = op[9:7];
        is_load  = (opc == 7'b0000011);
        is_store = (opc == 7'b0100011);
        is_mem   = is_load || is_store;
        we       = is_store;
        legal    = is_load ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f inside {3'd0, 3'd1, 3'd2});
        size     = 1 << f[1:0];
        off      = int'(a % 4);
        err      = is_mem && (!legal || (a % size) != 0);
        strb     = 4'b0000;
        lanes    = 32'h0;
        data     = 32'h0;
        if (!is_mem) begin
            data = a;
        end else if (!err && is_load) begin
            val = rd >> (8 * off);
            if (size == 4) begin
                data = rd;
            end else begin
                mask = (32'h1 << (8 * size)) - 32'h1;
                val  = val & mask;
                if (!f[2] && val[8*size-1]) val = val | ~mask;
                data = val;
            end
        end else if (!err && is_store) begin
            strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    val = sd >> (8 * (i - off));
                    lanes[8*i +: 8] = val[7:0];
                end
            end
        end
    endfunction

    // Present one op at the current negedge (DUT idle), respond, check, return idle at a negedge.
    // delay: index of the cycle carrying mem_ack (0 = REQ cycle); delay > TO means never ack.
    task automatic run_op(input logic [11:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int delay, input bit garbage);
        bit          is_mem, err, we;
        logic [31:0] data, lanes;
        logic [3:0]  strb;
        int          cyc;
        bit          tmo;
        model(op, a, sd, rd, is_mem, err, we, data, strb, lanes);
        tmo = delay > TO;
        check("in_ready before accept", in_ready, 1);
        in_valid   = 1'b1;
        operation  = op;
        alu_result = a;
        store_data = sd;
        @(negedge clk);
        in_valid   = 1'b0;
        operation  = 12'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
        if (!is_mem || err) begin
            check("direct out_valid", out_valid, 1);
            check("direct out_err", out_err, err);
            check("direct out_data", out_data, data);
            check("direct no mem_req", mem_req, 0);
        end else begin
            check("req mem_req", mem_req, 1);
            check("req mem_addr", mem_addr, {a[31:2], 2'b00});
            check("req mem_we", mem_we, we);
            check("req mem_wstrb", mem_wstrb, strb);
            check("req mem_wdata lanes", mem_wdata & lanemask(strb), lanes);
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 20) begin
                check("busy mem_req held", mem_req, 1);
                check("busy mem_addr stable", mem_addr, {a[31:2], 2'b00});
                check("busy in_ready low", in_ready, 0);
                mem_ack   = (cyc == delay);
                mem_rdata = (cyc == delay) ? rd : $urandom;
                if (garbage) begin
                    in_valid   = 1'b1;
                    operation  = 12'($urandom);
                    alu_result = $urandom;
                end
                @(negedge clk);
                mem_ack = 1'b0;
                cyc++;
            end
            in_valid = 1'b0;
            check("mem latency", cyc, tmo ? (1 + TO) : (delay + 1));
            check("mem out_valid", out_valid, 1);
            check("mem out_err", out_err, tmo);
            if (!tmo) check("mem out_data", out_data, data);
            check("done mem_req low", mem_req, 0);
        end
        @(negedge clk);
        check("pulse out_valid", out_valid, 0);
        check("pulse out_err", out_err, 0);
        check("back in_ready", in_ready, 1);
        if (!is_mem) check("held out_data", out_data, data);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        operation  = '0;
        alu_result = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_wstrb", mem_wstrb, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_err", out_err, 0);
        check("rst out_data", out_data, 0);
        rst = 1'b0;

        // addi pass-through
        run_op(12'b000000010011, 32'h1234, 32'h0, 32'h0, 0, 0);
        // LB / LBU of top byte, ack in REQ
        run_op(mkop(3'b000, 7'b0000011), 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        run_op(mkop(3'b100, 7'b0000011), 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        // SH to upper half, ack in the third WAIT cycle
        run_op(mkop(3'b001, 7'b0100011), 32'h202, 32'h0000_ABCD, 32'h0, 3, 0);
        check("sh wdata full", mem_wdata, 32'hABCD_ABCD);
        // misaligned LW
        run_op(mkop(3'b010, 7'b0000011), 32'h6, 32'h0, 32'h0, 0, 0);
        // illegal store funct3
        run_op(mkop(3'b100, 7'b0100011), 32'h10, 32'h55, 32'h0, 0, 0);
        // timeout, then a stray ack in IDLE
        run_op(mkop(3'b010, 7'b0000011), 32'h40, 32'h0, 32'h0, 99, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray ack out_valid", out_valid, 0);
        check("stray ack mem_req", mem_req, 0);
        check("stray ack in_ready", in_ready, 1);

        // reset in the middle of a WAIT
        in_valid   = 1'b1;
        operation  = mkop(3'b010, 7'b0100011);
        alu_result = 32'h80;
        store_data = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-rst mem_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst mem_req", mem_req, 0);
        check("mid rst in_ready", in_ready, 1);
        check("mid rst mem_addr", mem_addr, 0);
        check("mid rst mem_wdata", mem_wdata, 0);
        check("mid rst mem_we", mem_we, 0);
        check("mid rst mem_wstrb", mem_wstrb, 0);
        check("mid rst out_valid", out_valid, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late ack out_valid", out_valid, 0);
        check("late ack in_ready", in_ready, 1);
        run_op(mkop(3'b101, 7'b0000011), 32'h302, 32'h0, 32'h9876_1234, 1, 0);
        run_op(mkop(3'b000, 7'b0100011), 32'h301, 32'h0000_00A5, 32'h0, 0, 0);

        // randomized mix against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [6:0]  opc;
            logic [11:0] op;
            case ($urandom_range(0, 3))
                0:       opc = 7'b0000011;
                1:       opc = 7'b0100011;
                2:       opc = 7'b0010011;
                default: opc = 7'($urandom);
            endcase
            op = {2'($urandom), 3'($urandom_range(0, 7)), opc};
            run_op(op, $urandom, $urandom, $urandom, $urandom_range(0, TO - 1), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
